// File: rtl/fir_share_sched.sv
// Round-robin, packet-granular sharing of one fixed-latency FIR core; handshake to m_tvalid is FILT_LAT+2 cycles,
// and credits stall sources so filter output never overflows the FIFO. Optional per-channel pkt_cnt under FIR_PKT_CNT_EN.
module fir_share_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int OUT_W      = 32,
    parameter int FILT_LAT   = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]        filt_data_in,
    output logic                     filt_valid_in,
    output logic                     filt_sync_reset,
    input  logic [OUT_W-1:0]         filt_data_out,
    input  logic                     filt_valid_out,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [OUT_W-1:0]         m_tdata,
    output logic                     m_tlast,
    output logic [CH_W-1:0]          m_tdest,
`ifdef FIR_PKT_CNT_EN
    output logic [NUM_CH*16-1:0]     pkt_cnt,
`endif
    output logic                     busy,
    output logic                     tag_err
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = AW + 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, CLEAR} state_t;

    typedef struct packed {
        logic [OUT_W-1:0] dat;
        logic             last;
        logic [CH_W-1:0]  ch;
    } ent_t;

    state_t            state_q;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   cur_ch_q;
    logic              busy_q;
    logic              sync_rst_q;

    logic              in_vld_q;
    logic              in_last_q;
    logic [CH_W-1:0]   in_ch_q;
    logic [DATA_W-1:0] in_dat_q;

    logic [FILT_LAT-1:0] tag_vld_q;
    logic [FILT_LAT-1:0] tag_last_q;
    logic [CH_W-1:0]     tag_ch_q [FILT_LAT];
    logic                tag_err_q;

    logic [OCC_W-1:0]  inflight_q, inflight_d;
    logic [OCC_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    ent_t              mem [FIFO_DEPTH];

    logic              arb_hit;
    logic [CH_W-1:0]   arb_ch;
    logic              cur_vld, cur_last, hs;
    logic [DATA_W-1:0] cur_dat;
    logic [OCC_W-1:0]  occupancy;
    logic              credit_ok;
    logic              fifo_empty, fifo_full, push, pop;
    logic              exit_vld, exit_last;
    logic [CH_W-1:0]   exit_ch;
    ent_t              head, wr_ent;

    // Lowest offset from rr_q+1 wins; the loop runs backwards so the last assignment is the winner.
    always_comb begin
        logic [CH_W-1:0] cand;
        arb_hit = 1'b0;
        arb_ch  = '0;
        cand    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (s_tvalid[cand]) begin
                arb_hit = 1'b1;
                arb_ch  = cand;
            end
        end
    end

    assign cur_vld   = s_tvalid[cur_ch_q];
    assign cur_last  = s_tlast[cur_ch_q];
    assign cur_dat   = s_tdata[int'(cur_ch_q)*DATA_W +: DATA_W];

    assign occupancy = inflight_q + fifo_cnt_q;
    assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);
    assign hs        = (state_q == STREAM) && cur_vld && credit_ok;

    always_comb begin
        s_tready = '0;
        if (state_q == STREAM) begin
            s_tready[cur_ch_q] = credit_ok;
        end
    end

    assign exit_vld  = tag_vld_q[FILT_LAT-1];
    assign exit_last = tag_last_q[FILT_LAT-1];
    assign exit_ch   = tag_ch_q[FILT_LAT-1];

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == OCC_W'(FIFO_DEPTH));
    assign pop        = m_tvalid && m_tready;
    // A spurious validOut into a full FIFO is dropped rather than corrupting the head.
    assign push       = filt_valid_out && (!fifo_full || pop);

    assign inflight_d = inflight_q + OCC_W'(hs) - OCC_W'(exit_vld);
    assign fifo_cnt_d = fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= CH_W'(NUM_CH - 1);
            cur_ch_q   <= '0;
            busy_q     <= 1'b0;
            sync_rst_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        cur_ch_q <= arb_ch;
                        rr_q     <= arb_ch;
                        busy_q   <= 1'b1;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs && cur_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight_q == '0) begin
                        sync_rst_q <= 1'b1;
                        state_q    <= CLEAR;
                    end
                end
                CLEAR: begin
                    sync_rst_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_vld_q   <= 1'b0;
            in_last_q  <= 1'b0;
            in_ch_q    <= '0;
            in_dat_q   <= '0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            for (int i = 0; i < FILT_LAT; i++) begin
                tag_ch_q[i] <= '0;
            end
            inflight_q <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            in_vld_q <= hs;
            if (hs) begin
                in_last_q <= cur_last;
                in_ch_q   <= cur_ch_q;
                in_dat_q  <= cur_dat;
            end
            // The input register is the first latency stage, so the tag pipe trails it by one.
            tag_vld_q   <= {tag_vld_q[FILT_LAT-2:0], in_vld_q};
            tag_last_q  <= {tag_last_q[FILT_LAT-2:0], in_last_q};
            tag_ch_q[0] <= in_ch_q;
            for (int i = 1; i < FILT_LAT; i++) begin
                tag_ch_q[i] <= tag_ch_q[i-1];
            end
            inflight_q <= inflight_d;
            if (filt_valid_out != exit_vld) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign wr_ent.dat  = filt_data_out;
    assign wr_ent.last = exit_last;
    assign wr_ent.ch   = exit_ch;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    assign head     = mem[rd_ptr_q];
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? '0 : head.dat;
    assign m_tlast  = fifo_empty ? 1'b0 : head.last;
    assign m_tdest  = fifo_empty ? '0 : head.ch;

    assign filt_data_in    = in_dat_q;
    assign filt_valid_in   = in_vld_q;
    assign filt_sync_reset = sync_rst_q;
    assign busy            = busy_q;
    assign tag_err         = tag_err_q;

`ifdef FIR_PKT_CNT_EN
    logic [15:0] pkt_cnt_q [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (pop && head.last) begin
            pkt_cnt_q[head.ch] <= pkt_cnt_q[head.ch] + 16'd1;
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_cnt[i*16 +: 16] = pkt_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fir_share_sched.sv
// Scoreboard bench for fir_share_sched with a pure FILT_LAT delay standing in for the FIR core.
module tb_fir_share_sched;
    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int OW    = 32;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    s_tvalid;
    logic [NCH*DW-1:0] s_tdata;
    logic [NCH-1:0]    s_tlast;
    logic [NCH-1:0]    s_tready;
    logic [DW-1:0]     filt_data_in;
    logic              filt_valid_in;
    logic              filt_sync_reset;
    logic [OW-1:0]     filt_data_out;
    logic              filt_valid_out;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [OW-1:0]     m_tdata;
    logic              m_tlast;
    logic [1:0]        m_tdest;
    logic              busy;
    logic              tag_err;
`ifdef FIR_PKT_CNT_EN
    logic [NCH*16-1:0] pkt_cnt;
`endif

    fir_share_sched #(.NUM_CH(NCH), .DATA_W(DW), .OUT_W(OW), .FILT_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
        .filt_data_in(filt_data_in), .filt_valid_in(filt_valid_in), .filt_sync_reset(filt_sync_reset),
        .filt_data_out(filt_data_out), .filt_valid_out(filt_valid_out),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tdest(m_tdest),
`ifdef FIR_PKT_CNT_EN
        .pkt_cnt(pkt_cnt),
`endif
        .busy(busy), .tag_err(tag_err)
    );

    // Filter stand-in: pure LAT-cycle delay, plus a one-cycle spurious validOut on demand.
    logic [LAT-1:0] v_pipe;
    logic [31:0]    d_pipe [LAT];
    logic           inj = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            v_pipe <= '0;
            for (int i = 0; i < LAT; i++) d_pipe[i] <= '0;
        end else begin
            v_pipe    <= {v_pipe[LAT-2:0], filt_valid_in};
            d_pipe[0] <= filt_data_in;
            for (int i = 1; i < LAT; i++) d_pipe[i] <= d_pipe[i-1];
        end
    end
    assign filt_valid_out = v_pipe[LAT-1] | inj;
    assign filt_data_out  = inj ? 32'h0000DEAD : d_pipe[LAT-1];

    typedef struct packed {logic [31:0] d; logic l;} beat_t;
    typedef struct packed {logic [31:0] d; logic l; logic [1:0] ch;} exp_t;

    beat_t srcq [NCH][$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    sync_cnt = 0;
    int    acc_cnt [NCH] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (filt_sync_reset) sync_cnt <= sync_cnt + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source driver: one process owns s_tvalid/s_tdata/s_tlast for all channels.
    initial begin
        logic hs [NCH];
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) hs[i] = s_tvalid[i] && s_tready[i] && !reset;
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (hs[i] && srcq[i].size() > 0) begin
                    void'(srcq[i].pop_front());
                    acc_cnt[i]++;
                end
                if (srcq[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = srcq[i][0].d;
                    s_tlast[i]           = srcq[i][0].l;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every popped beat is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got data %0h dest %0d, nothing expected", m_tdata, m_tdest);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_tdata, e.d);
                    chk("out_last", m_tlast, e.l);
                    chk("out_dest", m_tdest, e.ch);
                end
            end
        end
    end

    task automatic send(input int ch, input logic [31:0] base, input int n);
        beat_t b;
        exp_t  e;
        logic [1:0] c2;
        c2 = ch[1:0];
        for (int k = 0; k < n; k++) begin
            b.d = base + k;
            b.l = (k == n - 1);
            srcq[ch].push_back(b);
            e.d  = b.d;
            e.l  = b.l;
            e.ch = c2;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush_queues();
        for (int i = 0; i < NCH; i++) srcq[i].delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_queues();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || m_tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d outputs outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, s0, a0, nhs;
`ifdef FIR_PKT_CNT_EN
        logic [15:0] pc0;
`endif
        // Reset state
        #1;
        chk("reset_out", {m_tvalid, m_tlast, m_tdest, m_tdata, s_tready}, '0);
        chk("reset_filt", {filt_valid_in, filt_sync_reset, filt_data_in, busy, tag_err}, '0);
        do_reset();

        // Single packet on ch0, latency and one syncReset pulse
        s0 = sync_cnt;
        send(0, 32'h10, 5);
        t0 = -1;
        t1 = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_tvalid[0] && s_tready[0]) begin t0 = cyc; break; end
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (m_tvalid) begin t1 = cyc; break; end
        end
        chk("first_latency", t1 - t0, 10);
        wait_drain("single", 200);
        chk("single_sync_pulses", sync_cnt - s0, 1);

        // Round-robin ch1/ch3: grant order ch1, ch3, ch1, ch3
        do_reset();
        send(1, 32'h100, 3);
        send(3, 32'h300, 3);
        send(1, 32'h110, 3);
        send(3, 32'h310, 3);
        wait_drain("rr", 400);

        // Back-pressure: only FIFO_DEPTH beats may be accepted while m_tready is low
        do_reset();
        m_tready = 1'b0;
        a0 = acc_cnt[2];
        send(2, 32'h2000, 40);
        repeat (80) @(negedge clk);
        chk("bp_accepted", acc_cnt[2] - a0, DEPTH);
        chk("bp_tready_low", s_tready[2], 1'b0);
        chk("bp_tvalid_held", m_tvalid, 1'b1);
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_drain("bp", 600);
        chk("bp_all_accepted", acc_cnt[2] - a0, 40);
        chk("bp_tag_err", tag_err, 1'b0);

        // Alternating single-beat packets, one syncReset each
        do_reset();
        s0 = sync_cnt;
        send(0, 32'h40, 1);
        send(1, 32'h41, 1);
        send(0, 32'h42, 1);
        send(1, 32'h43, 1);
        wait_drain("onebeat", 300);
        chk("onebeat_sync_pulses", sync_cnt - s0, 4);

        // Reset during beat 3 of an 8-beat ch2 packet
        do_reset();
        send(2, 32'h500, 8);
        nhs = 0;
        for (int n = 0; n < 60 && nhs < 3; n++) begin
            @(negedge clk);
            if (s_tvalid[2] && s_tready[2]) nhs++;
        end
        reset = 1'b1;
        flush_queues();
        #1;
        chk("midrst_out", {m_tvalid, m_tlast, m_tdest, m_tdata, s_tready}, '0);
        chk("midrst_filt", {filt_valid_in, filt_sync_reset, filt_data_in, busy, tag_err}, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        send(0, 32'h600, 2);
        send(2, 32'h610, 2);
        wait_drain("midrst", 300);

        // Spurious validOut sets a sticky tag_err
        do_reset();
        begin
            exp_t e;
            e.d  = 32'h0000DEAD;
            e.l  = 1'b0;
            e.ch = 2'd0;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("tag_err_set", tag_err, 1'b1);
`ifdef FIR_PKT_CNT_EN
        pc0 = pkt_cnt[15:0];
`endif
        send(0, 32'h700, 2);
        wait_drain("tagerr", 200);
        chk("tag_err_sticky", tag_err, 1'b1);
`ifdef FIR_PKT_CNT_EN
        chk("pkt_cnt_ch0", pkt_cnt[15:0] - pc0, 16'd1);
`endif
        reset = 1'b1;
        #1;
        chk("tag_err_cleared", tag_err, 1'b0);
`ifdef FIR_PKT_CNT_EN
        chk("pkt_cnt_reset", pkt_cnt, '0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_share_sched.md
Name: fir_share_sched

Overview:
- Packet-granular scheduler that time-shares one fixed-latency FIR filter core (clk/reset/enb/dataIn/validIn/syncReset/dataOut/validOut) between NUM_CH AXI-stream sources.
- Grants one channel per packet (round-robin) and drains the filter after each packet.
- Pulses the filter's syncReset so no history leaks between channels.
- Returns results on one AXI-stream master tagged with tdest = source channel; a credit scheme guarantees filter output is never dropped under back-pressure.

Parameters:
- NUM_CH, 4, number of source channels (2..8).
- DATA_W, 32, filter input sample width.
- OUT_W, 32, filter output sample width.
- FILT_LAT, 8, filter latency: validOut exactly FILT_LAT cycles after validIn (enb held 1).
- FIFO_DEPTH, 16, output FIFO depth, power of 2, >= FILT_LAT+2.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tdata  in  NUM_CH*DATA_W  packed samples; ch i at [i*DATA_W +: DATA_W].
- s_tlast  in  NUM_CH  per-channel end of packet.
- s_tready  out  NUM_CH  per-channel ready.
- filt_data_in  out  DATA_W  to filter dataIn.
- filt_valid_in  out  1  to filter validIn.
- filt_sync_reset  out  1  to filter syncReset.
- filt_data_out  in  OUT_W  from filter dataOut.
- filt_valid_out  in  1  from filter validOut.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  OUT_W  result sample.
- m_tlast  out  1  last result of a packet.
- m_tdest  out  $clog2(NUM_CH)  originating channel.
- busy  out  1  FSM not in IDLE.
- tag_err  out  1  sticky: filt_valid_out disagrees with the tag pipeline.

Behaviour:
- Reset values:
  - All outputs 0; FSM = IDLE; FIFO empty; tag pipe cleared.
  - RR pointer = NUM_CH-1, so ch0 wins first.
  - Reset asserted mid-packet discards in-flight and FIFO data.
- FSM IDLE:
  - Scan s_tvalid starting at pointer+1, wrapping.
  - On a hit, register cur_ch, move pointer to cur_ch, go to STREAM.
  - No hit: stay in IDLE.
  - The arbitration cycle accepts no data.
- FSM STREAM:
  - s_tready[cur_ch] = credit_ok (combinational); all other s_tready = 0.
  - Handshake (s_tvalid & s_tready on cur_ch) at cycle t: filt_data_in/filt_valid_in registered, asserted at t+1.
  - In the same cycle (t+1), tag {valid, last, ch} enters the FILT_LAT-deep tag shift register.
  - Accepted beat with tlast → DRAIN.
- FSM DRAIN:
  - All s_tready = 0.
  - When inflight == 0 (tag pipe and input register empty) → CLEAR.
  - The FIFO need not be empty.
- FSM CLEAR:
  - filt_sync_reset = 1 for exactly one cycle → IDLE.
  - Minimum gap between packets: DRAIN + CLEAR + IDLE arbitration.
- Credits:
  - occupancy = inflight + fifo_count; credit_ok = occupancy < FIFO_DEPTH.
  - Count the FIFO write and read of the same cycle in that cycle's occupancy; no overflow is possible.
- Return path:
  - filt_valid_out writes {filt_data_out, tag.last, tag.ch} into the FIFO.
  - tag_err sets if filt_valid_out != tag.valid at the tag pipe exit; cleared only by reset.
- Output FIFO:
  - First-word fall-through; m_tvalid = !empty.
  - Pop on m_tvalid & m_tready; m_t* stable while stalled.
- Latency: input handshake at t → m_tvalid at t+2+FILT_LAT when the FIFO was empty.
- Boundaries:
  - Single-beat packet (tlast on first beat) valid.
  - Source deasserting tvalid mid-packet keeps the grant (no timeout).
  - Simultaneous FIFO push and pop at full is legal.
  - m_tready held low stalls input once occupancy reaches FIFO_DEPTH.

Optional Feature:
- Macro FIR_PKT_CNT_EN.
- When defined:
  - Adds output pkt_cnt [NUM_CH*16], 16-bit per-channel counters, incremented when a beat with m_tlast pops from the FIFO; wraps at 0xFFFF→0.
  - Reset to 0.
- When undefined: port and logic absent.

Test Plan:
- Bench filter model: pure FILT_LAT=8 delay; FIFO_DEPTH=16; NUM_CH=4.
- Single packet, ch0 sends 5 beats 0x10..0x14, tlast on beat 5, m_tready=1 → m_tdata 0x10..0x14 with tdest=0 and tlast only on 0x14. First m_tvalid 10 cycles after the first handshake. One filt_sync_reset pulse after DRAIN.
- Round-robin, ch1 and ch3 both hold 3-beat packets from reset → order ch1, ch3. After a further ch1 packet and ch3 request together, ch3 is not skipped: grant order continues ch1, ch3, ch1, ch3. No interleaving within m_tdest runs.
- Back-pressure, m_tready=0 while ch2 streams 40 beats → at most 16 beats accepted, s_tready[2] low thereafter. Release m_tready → all 40 emerge in order, none lost, tag_err=0.
- Single-beat packets, ch0 and ch1 alternate 1-beat tlast packets → each produces one result with tlast=1. filt_sync_reset pulses between every packet.
- Reset mid-packet, assert reset during beat 3 of an 8-beat ch2 packet → all outputs 0 and FIFO empty immediately. After release, ch0 wins first and no stale data appears.
- Tag mismatch, model injects a spurious validOut → tag_err=1 and stays 1 until reset. With FIR_PKT_CNT_EN, pkt_cnt[ch0] increments by 1 per completed ch0 packet.
